// File: rtl/disc_write_fetch.sv
// Instruction fetch/prefetch stage for the disc write sequencer.
// Keeps a 3-byte lookahead queue filled from a 1-cycle-latency program RAM,
// so that a valid byte sits on mdat the cycle after every sequencer pop.
module disc_write_fetch #(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic                  addr_load,
  input  logic                  go,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_rd,
  input  logic [7:0]            ram_rdata,
  output logic [7:0]            mdat,
  input  logic                  maddr_inc,
  output logic                  writer_start,
  input  logic                  writer_running,
  output logic [ADDR_WIDTH-1:0] cur_addr,
  output logic                  ready,
  output logic                  done,
  output logic                  underrun
);

  typedef enum logic [2:0] {StIdle, StPrime, StReady, StRun, StDone} state_e;

  localparam logic [7:0] StopByte = 8'h7F;

  state_e                  state_q, state_d;
  logic [7:0]              q_q [3];
  logic [7:0]              q_d [3];
  logic [1:0]              count_q, count_d;
  logic                    pend_q, pend_d;      // RAM data returning this cycle
  logic [ADDR_WIDTH-1:0]   fptr_q, fptr_d;
  logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic                    ram_rd_q, ram_rd_d;
  logic                    ready_q, ready_d;
  logic                    wstart_q, wstart_d;
  logic                    done_q, done_d;
  logic                    underrun_q, underrun_d;
  logic                    run_q, run_qq;

  logic                    pop;
  logic [1:0]              cnt_after_pop;
  logic [2:0]              occ;                 // bytes held plus reads not yet landed
  logic                    flush;

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      q_q        <= '{default: 8'h00};
      count_q    <= 2'd0;
      pend_q     <= 1'b0;
      fptr_q     <= '0;
      cur_addr_q <= '0;
      ram_addr_q <= '0;
      ram_rd_q   <= 1'b0;
      ready_q    <= 1'b0;
      wstart_q   <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      run_q      <= 1'b0;
      run_qq     <= 1'b0;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      count_q    <= count_d;
      pend_q     <= pend_d;
      fptr_q     <= fptr_d;
      cur_addr_q <= cur_addr_d;
      ram_addr_q <= ram_addr_d;
      ram_rd_q   <= ram_rd_d;
      ready_q    <= ready_d;
      wstart_q   <= wstart_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
      run_q      <= writer_running;
      run_qq     <= run_q;
    end
  end

  // Queue update, read issue and FSM next state.
  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    pend_d     = ram_rd_q;
    fptr_d     = fptr_q;
    ram_addr_d = ram_addr_q;
    ram_rd_d   = 1'b0;
    wstart_d   = 1'b0;
    done_d     = done_q;

    pop           = maddr_inc && (count_q != 2'd0);
    cnt_after_pop = count_q - {1'b0, pop};
    occ           = {1'b0, count_q} - {2'b0, pop} + {2'b0, pend_q} + {2'b0, ram_rd_q};

    if (pop) begin
      q_d[0] = q_q[1];
      q_d[1] = q_q[2];
    end
    // Returning byte lands just behind whatever survives the pop.
    if (pend_q) begin
      case (cnt_after_pop)
        2'd0:    q_d[0] = ram_rdata;
        2'd1:    q_d[1] = ram_rdata;
        2'd2:    q_d[2] = ram_rdata;
        default: ;
      endcase
    end
    count_d    = cnt_after_pop + {1'b0, pend_q};
    cur_addr_d = pop ? cur_addr_q + ADDR_WIDTH'(1) : cur_addr_q;
    underrun_d = underrun_q | (maddr_inc && (count_q <= 2'd1));

    case (state_q)
      StPrime: if (count_d == 2'd3) state_d = StReady;
      StReady: begin
        if (go) begin
          state_d  = StRun;
          wstart_d = 1'b1;
        end
      end
      StRun: begin
        if (run_qq && !run_q) begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase

    if ((state_d == StPrime || state_d == StReady || state_d == StRun) && (occ < 3'd3)) begin
      ram_rd_d   = 1'b1;
      ram_addr_d = fptr_q;
      fptr_d     = fptr_q + ADDR_WIDTH'(1);
    end

    // Reload restarts priming; the first read goes out immediately at start_addr.
    flush = addr_load && (state_q != StRun);
    if (flush) begin
      state_d    = StPrime;
      count_d    = 2'd0;
      pend_d     = 1'b0;
      ram_rd_d   = 1'b1;
      ram_addr_d = start_addr;
      fptr_d     = start_addr + ADDR_WIDTH'(1);
      cur_addr_d = start_addr;
      wstart_d   = 1'b0;
      done_d     = 1'b0;
      underrun_d = 1'b0;
    end

    ready_d = (state_d == StReady);
  end

  assign mdat         = (count_q != 2'd0) ? q_q[0] : StopByte;
  assign ram_addr     = ram_addr_q;
  assign ram_rd       = ram_rd_q;
  assign cur_addr     = cur_addr_q;
  assign ready        = ready_q;
  assign writer_start = wstart_q;
  assign done         = done_q;
  assign underrun     = underrun_q;

endmodule

// File: doc/disc_write_fetch.md
# disc_write_fetch

Instruction fetch and prefetch stage feeding the disc write sequencer. It loads a start address from the host and reads write-program bytes from the synchronous 1-cycle-latency write-program RAM. It keeps a 3-byte lookahead queue so a valid instruction byte is always on `mdat` the cycle after each `maddr_inc`. It also issues the single-cycle `start` strobe to the sequencer and reports completion to the host.

## Interface
- `ADDR_WIDTH`, 16, width of the program RAM address and address counters.
- `clock`  in  1  master clock, shared with the write sequencer.
- `reset`  in  1  asynchronous, active-high reset.
- `start_addr`  in  ADDR_WIDTH  host program start address, sampled on `addr_load`.
- `addr_load`  in  1  host pulse that flushes the queue and begins priming from `start_addr`.
- `go`  in  1  host request to start writing. Level; acted on only in READY.
- `ram_addr`  out  ADDR_WIDTH  program RAM read address.
- `ram_rd`  out  1  RAM read enable. Data appears on `ram_rdata` exactly 1 cycle later.
- `ram_rdata`  in  8  RAM read data.
- `mdat`  out  8  current instruction byte to the sequencer (queue head).
- `maddr_inc`  in  1  sequencer pop strobe, one cycle per consumed byte.
- `writer_start`  out  1  one-cycle start strobe to the sequencer.
- `writer_running`  in  1  sequencer running status.
- `cur_addr`  out  ADDR_WIDTH  RAM address of the byte currently on `mdat`.
- `ready`  out  1  queue primed, in READY state.
- `done`  out  1  sticky: the sequencer has stopped after a run.
- `underrun`  out  1  sticky: a pop occurred with no byte behind the head.

## Operation
- Queue: 3 entries, Q0..Q2. `count` 0..3. `mdat` = Q0 when `count` ≥ 1, otherwise 8'h7F (STOP).
- `fptr`: next RAM address to read. `inflight`: 1 when a read was issued the previous cycle.
- Read issue: in PRIME, READY or RUN, assert `ram_rd` with `ram_addr` = `fptr` when `count` + `inflight` − `pop` < 3. `fptr` increments on each issued read and wraps modulo 2^ADDR_WIDTH (0xFFFF → 0x0000).
- Returned data is written at index `count` − `pop`.
- Pop: `maddr_inc` with `count` ≥ 1 shifts the queue down (Q0←Q1, Q1←Q2) and increments `cur_addr` modulo 2^ADDR_WIDTH.
  - If `count` ≤ 1 at the pop, set `underrun`.
  - If `count` = 0, the pop is ignored apart from setting `underrun`.
  - A pop and a fill in the same cycle are both applied.
- States:
  - IDLE: no reads. `addr_load` → PRIME.
  - PRIME: fill the queue. `count` = 3 → READY.
  - READY: `ready` = 1. `go` → pulse `writer_start`, go to RUN.
  - RUN: serve pops and refill. Falling edge of `writer_running` (registered 1→0) → DONE, set `done`.
  - DONE: no reads. `addr_load` → PRIME.
- `addr_load` in PRIME, READY or DONE:
  - Next edge: flush queue (`count` = 0), discard any in-flight return, `fptr` = `cur_addr` = `start_addr`, clear `done` and `underrun`, state PRIME.
- `addr_load` in RUN is ignored. `go` outside READY is ignored.
- `maddr_inc` outside RUN: pops still applied, because the sequencer owns the address. Used for bench recovery only.

## Timing
- Reset values:
  - `ram_addr` 0, `ram_rd` 0.
  - `mdat` 8'h7F, `cur_addr` 0.
  - `ready` 0, `writer_start` 0, `done` 0, `underrun` 0.
  - State IDLE, `count` 0.
- Reset is asynchronous. Asserting it mid-run aborts immediately, and the next cycle restarts from IDLE.
- Priming: `addr_load` at edge T gives the first `ram_rd` in cycle T+1 and `count` = 3 at edge T+4. `ready` is high from the cycle after edge T+4.
- `go` sampled high at edge R gives `writer_start` high for exactly cycle R+1, and RUN from R+1.
- Pop latency: `maddr_inc` sampled at edge P gives the new `mdat` and `cur_addr` valid in cycle P+1, with no bubble.
- Sustained rate: one pop every cycle for 2 pops, then one pop every 2 cycles indefinitely, without underrun. The sequencer's minimum spacing is 2 cycles.
- `writer_running` is registered once. `done` rises 2 cycles after `writer_running` falls.
- Outputs are registered, except `mdat`, which is a mux of registered Q0.

## Test plan
- Reset, then idle: all outputs at reset values. `mdat` = 8'h7F. No `ram_rd` for 20 cycles.
- Priming: RAM[0x0100..] = 80,02,02,7F. `addr_load` with `start_addr` = 0x0100 → `ram_rd` at 0x0100, 0x0101, 0x0102 on consecutive cycles. `ready` 4 cycles after the load edge. `mdat` = 0x80, `cur_addr` = 0x0100.
- Run: `go`, then `maddr_inc` every 2 cycles → `writer_start` single pulse. `mdat` sequence 80,02,02,7F with `cur_addr` 0x0100..0x0103. `underrun` stays 0.
- Completion: drop `writer_running` after 4 pops → `done` = 1 two cycles later. `ram_rd` stops. A new `addr_load` clears `done`.
- Wrap: `start_addr` = 0xFFFE, RAM[0xFFFE] = AA, [0xFFFF] = BB, [0x0000] = CC → `ram_addr` 0xFFFE, 0xFFFF, 0x0000. Pops give `mdat` AA, BB, CC and `cur_addr` 0x0000 after two pops.
- Underrun and reset: 4 back-to-back `maddr_inc` in RUN → `underrun` set on the third pop. `mdat` = 8'h7F when `count` = 0. Asynchronous `reset` mid-run → all outputs return to reset values within the same cycle.
